// File: rtl/alu_8bit.sv
// alu_8bit: registered 8-bit ALU (accum op data) with accumulator-zero flag.
// Ports: clk, rst_n (sync, active-low), opcode[2:0], data[7:0], accum[7:0],
//   out[7:0], zero, carry (only when ALU_CARRY_EN is defined).
module alu_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [7:0] data,
  input  logic [7:0] accum,
  output logic [7:0] out,
  output logic       zero
`ifdef ALU_CARRY_EN
  ,
  output logic       carry
`endif
);

  localparam logic [2:0] OP_PASS0 = 3'b000;
  localparam logic [2:0] OP_PASS1 = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_PASSD = 3'b101;
  localparam logic [2:0] OP_PASS6 = 3'b110;
  localparam logic [2:0] OP_PASS7 = 3'b111;

`ifdef ALU_CARRY_EN
  logic [8:0] sum;
  assign sum = {1'b0, accum} + {1'b0, data};
`else
  logic [7:0] sum;
  assign sum = accum + data;
`endif

  logic [7:0] res;

  // Default arm only catches X/Z opcodes; it propagates X in sim.
  always_comb begin
    res = 8'h00;
    case (opcode)
      OP_PASS0: res = accum;
      OP_PASS1: res = accum;
      OP_ADD:   res = sum[7:0];
      OP_AND:   res = accum & data;
      OP_XOR:   res = accum ^ data;
      OP_PASSD: res = data;
      OP_PASS6: res = accum;
      OP_PASS7: res = accum;
      default:  res = 8'hxx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out  <= 8'h00;
      zero <= 1'b0;
    end else begin
      out  <= res;
      zero <= (accum == 8'h00);
    end
  end

`ifdef ALU_CARRY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      carry <= 1'b0;
    else
      carry <= (opcode == OP_ADD) & sum[8];
  end
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: directed self-checking bench for alu_8bit.
// Drives on negedge, checks #1 after each posedge.
module tb_alu_8bit;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic [7:0] data;
  logic [7:0] accum;
  logic [7:0] out;
  logic       zero;
`ifdef ALU_CARRY_EN
  logic       carry;
`endif

  int tests;
  int fails;

  alu_8bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .data   (data),
    .accum  (accum),
    .out    (out),
    .zero   (zero)
`ifdef ALU_CARRY_EN
    ,
    .carry  (carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(
    input logic       r,
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] d
  );
    @(negedge clk);
    rst_n  = r;
    opcode = op;
    accum  = a;
    data   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [7:0] eo,
    input logic       ez,
    input logic       ec
  );
    tests++;
    assert (out === eo) else begin
      fails++;
      $error("FAIL %s out: got %h want %h", tag, out, eo);
    end
    tests++;
    assert (zero === ez) else begin
      fails++;
      $error("FAIL %s zero: got %b want %b", tag, zero, ez);
    end
`ifdef ALU_CARRY_EN
    tests++;
    assert (carry === ec) else begin
      fails++;
      $error("FAIL %s carry: got %b want %b", tag, carry, ec);
    end
`else
    if (ec === 1'bx) $display("[TB] note: carry unused");
`endif
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    opcode = 3'b010;
    accum  = 8'h33;
    data   = 8'hAA;

    // reset held two edges with ADD pending
    drive(1'b0, 3'b010, 8'h33, 8'hAA);
    chk("rst1", 8'h00, 1'b0, 1'b0);
    drive(1'b0, 3'b010, 8'h33, 8'hAA);
    chk("rst2", 8'h00, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 8'h33, 8'hAA);
    chk("rel_add", 8'hDD, 1'b0, 1'b0);

    // pass opcodes
    drive(1'b1, 3'b000, 8'h00, 8'hFF);
    chk("pass0_z", 8'h00, 1'b1, 1'b0);
    drive(1'b1, 3'b000, 8'h55, 8'h00);
    chk("pass0", 8'h55, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 8'hCC, 8'h00);
    chk("pass1", 8'hCC, 1'b0, 1'b0);
    drive(1'b1, 3'b110, 8'hFF, 8'hF0);
    chk("pass6", 8'hFF, 1'b0, 1'b0);
    drive(1'b1, 3'b111, 8'hCC, 8'h0F);
    chk("pass7", 8'hCC, 1'b0, 1'b0);

    // arithmetic / logic
    drive(1'b1, 3'b010, 8'h33, 8'hAA);
    chk("add", 8'hDD, 1'b0, 1'b0);
    drive(1'b1, 3'b011, 8'h0F, 8'h33);
    chk("and", 8'h03, 1'b0, 1'b0);
    drive(1'b1, 3'b100, 8'hF0, 8'h55);
    chk("xor", 8'hA5, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 8'hFF, 8'h01);
    chk("add_wrap", 8'h00, 1'b0, 1'b1);

    // PASSD with zero accumulator: flag ignores out
    drive(1'b1, 3'b101, 8'h00, 8'hAA);
    chk("passd_aa", 8'hAA, 1'b1, 1'b0);
    drive(1'b1, 3'b101, 8'h00, 8'hCC);
    chk("passd_cc", 8'hCC, 1'b1, 1'b0);

    // back-to-back through all opcodes
    drive(1'b1, 3'b000, 8'h12, 8'h34);
    chk("b2b_0", 8'h12, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 8'h00, 8'h77);
    chk("b2b_1", 8'h00, 1'b1, 1'b0);
    drive(1'b1, 3'b010, 8'h80, 8'h80);
    chk("b2b_2", 8'h00, 1'b0, 1'b1);
    drive(1'b1, 3'b011, 8'hF0, 8'h3C);
    chk("b2b_3", 8'h30, 1'b0, 1'b0);
    drive(1'b1, 3'b100, 8'hAA, 8'hFF);
    chk("b2b_4", 8'h55, 1'b0, 1'b0);
    drive(1'b1, 3'b101, 8'h01, 8'h9E);
    chk("b2b_5", 8'h9E, 1'b0, 1'b0);
    drive(1'b1, 3'b110, 8'h7E, 8'h00);
    chk("b2b_6", 8'h7E, 1'b0, 1'b0);
    drive(1'b1, 3'b111, 8'h00, 8'h01);
    chk("b2b_7", 8'h00, 1'b1, 1'b0);

    // result holds until the next edge
    @(negedge clk);
    chk("hold", 8'h00, 1'b1, 1'b0);

    // mid-stream reset during ADD run
    drive(1'b1, 3'b010, 8'h10, 8'h20);
    chk("ms_add1", 8'h30, 1'b0, 1'b0);
    drive(1'b0, 3'b010, 8'hF0, 8'h20);
    chk("ms_rst", 8'h00, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 8'h40, 8'h04);
    chk("ms_add2", 8'h44, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 8'hF0, 8'h20);
    chk("ms_add3", 8'h10, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_8bit.md
# alu_8bit

Registered 8-bit arithmetic/logic unit for the 8-bit RISC CPU datapath. It combines the accumulator with the data-bus operand according to a 3-bit opcode. It produces an 8-bit result and a zero flag, both registered. The flag reflects the accumulator, and the control unit uses it for skip-if-zero decisions.

## Interface
- Clocking: one clock; reset is synchronous and active-low.
- Parameters: none. Width is fixed at 8 bits.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous active-low reset.
- `opcode`, input, 3: operation select.
- `data`, input, 8: operand from the data bus.
- `accum`, input, 8: operand from the accumulator.
- `out`, output, 8: registered result.
- `zero`, output, 1: registered flag; 1 when the sampled `accum` equals 0x00.
- `carry`, output, 1: registered carry-out. Present only when `ALU_CARRY_EN` is defined.

## Operation
Opcode decode:
- 000 PASS0: `out = accum`
- 001 PASS1: `out = accum`
- 010 ADD: `out = (accum + data)[7:0]`, wrapping modulo 256.
- 011 AND: `out = accum & data`
- 100 XOR: `out = accum ^ data`
- 101 PASSD: `out = data`
- 110 PASS6: `out = accum`
- 111 PASS7: `out = accum`

Flag and edge-case rules:
- `zero = (accum == 8'h00)` for every opcode. It is independent of `out`.
  - Example: PASSD with accum=0x00, data=0xAA gives out=0xAA and zero=1.
- No overflow or saturation. ADD of 0xFF + 0x01 gives 0x00.
- Any X/Z bit on `opcode` drives `out` to 8'hxx in simulation. Synthesis treats this as a don't-care.
- No internal state other than the output registers.
- Outputs never depend on previous results.

## Timing
- Latency is one cycle. Inputs are sampled on a rising `clk` edge, and `out`/`zero`/`carry` reflect them immediately after that edge.
- Results hold until the next rising edge.
- Inputs may change at any time between edges. Only values at the edge matter.
- Reset, when `rst_n` = 0 at a rising edge:
  - `out` = 8'h00, `zero` = 0, `carry` = 0.
  - Reset takes priority over the opcode.
- On the first edge with `rst_n` = 1, normal results are loaded. No recovery cycles.
- Reset asserted mid-stream discards the result of that edge. The outputs show reset values.
- Back-to-back operations every cycle are supported. No handshake or stall.

## Configuration
- `ALU_CARRY_EN` defined:
  - Adds the `carry` port.
  - On ADD, `carry` = bit 8 of the 9-bit sum `accum + data`.
  - For all other opcodes, `carry` = 0.
  - Registered with the same latency and reset as `out`.
- `ALU_CARRY_EN` undefined:
  - No `carry` port and no carry logic.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst_n` = 0 for 2 edges with opcode=ADD, accum=0x33, data=0xAA.
  - Expect out=0x00, zero=0 (and carry=0) after each edge.
  - Release reset; expect out=0xDD, zero=0 after the next edge.
- Pass opcodes:
  - PASS0, accum=0x00, data=0xFF → out=0x00, zero=1.
  - PASS0, accum=0x55 → out=0x55, zero=0.
  - PASS1, accum=0xCC → out=0xCC, zero=0.
  - PASS6, accum=0xFF, data=0xF0 → out=0xFF, zero=0.
  - PASS7, accum=0xCC, data=0x0F → out=0xCC, zero=0.
- Arithmetic and logic:
  - ADD 0x33 + 0xAA → out=0xDD, zero=0.
  - AND 0x0F & 0x33 → out=0x03.
  - XOR 0xF0 ^ 0x55 → out=0xA5.
  - ADD 0xFF + 0x01 → out=0x00, zero=0, carry=1 (carry only with `ALU_CARRY_EN`).
- PASSD with zero accumulator:
  - accum=0x00, data=0xAA → out=0xAA, zero=1.
  - accum=0x00, data=0xCC → out=0xCC, zero=1.
- Back-to-back: change opcode/operands every cycle across all 8 opcodes.
  - Each result appears exactly one edge after its inputs were sampled.
  - No carry-over between cycles.
- Mid-stream reset: drop `rst_n` for one edge during an ADD sequence.
  - Expect out=0x00, zero=0 for that edge only.
  - The next edge resumes correct results.
